// File: rtl/line_burst_pkg.sv
// Shared constants, state encodings and helpers for the line burst adapter.
// Optional counters live behind LINE_BURST_ADAPTER_PERF_EN in the top.
package line_burst_pkg;

  localparam int BEATS       = 4;
  localparam int BEAT_W      = 64;
  localparam int LINE_W      = BEATS * BEAT_W;
  localparam int ADDR_W      = 32;
  localparam int OFFSET_BITS = 5;
  localparam int BEAT_IW     = $clog2(BEATS);
  localparam int PERF_W      = 32;

  typedef logic [1:0]         state_t;
  typedef logic [BEAT_IW-1:0] beat_t;
  typedef logic [ADDR_W-1:0]  addr_t;
  typedef logic [BEAT_W-1:0]  beat_data_t;
  typedef logic [LINE_W-1:0]  line_t;
  typedef logic [PERF_W-1:0]  perf_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t READ  = 2'd1;
  localparam state_t WRITE = 2'd2;
  localparam state_t DONE  = 2'd3;

  localparam beat_t LAST_BEAT = beat_t'(BEATS - 1);

  function automatic addr_t line_align(input addr_t a);
    return {a[ADDR_W-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
  endfunction

  function automatic perf_t sat_inc(input perf_t v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/line_burst_adapter_if.sv
// Line-side and burst-side signal bundle of the line burst adapter.
// slave is the adapter's view; master is the arbiter/memory-model view.
interface line_burst_adapter_if;
  import line_burst_pkg::*;

  addr_t      line_address;
  logic       line_read;
  logic       line_write;
  line_t      line_wdata;
  line_t      line_rdata;
  logic       line_resp;

  addr_t      burst_address;
  logic       burst_read;
  logic       burst_write;
  beat_data_t burst_wdata;
  beat_data_t burst_rdata;
  logic       burst_resp;

  modport slave (
    input  line_address,
    input  line_read,
    input  line_write,
    input  line_wdata,
    output line_rdata,
    output line_resp,
    output burst_address,
    output burst_read,
    output burst_write,
    output burst_wdata,
    input  burst_rdata,
    input  burst_resp
  );

  modport master (
    output line_address,
    output line_read,
    output line_write,
    output line_wdata,
    input  line_rdata,
    input  line_resp,
    input  burst_address,
    input  burst_read,
    input  burst_write,
    input  burst_wdata,
    output burst_rdata,
    output burst_resp
  );

endinterface

// File: rtl/line_burst_adapter_beat_buffer.sv
// line_beat_buffer: read line assembled beat by beat, plus a write line
// loaded whole and presented one beat at a time.
module line_beat_buffer
  import line_burst_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       cap_en,
  input  beat_t      cap_idx,
  input  beat_data_t cap_data,
  input  logic       load_en,
  input  line_t      load_data,
  input  beat_t      sel_idx,
  output line_t      cap_line,
  output beat_data_t sel_data
);

  line_t load_line;

  // Kept separate so a write burst never disturbs the last read line.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap_line <= '0;
    end else if (cap_en) begin
      cap_line[cap_idx*BEAT_W +: BEAT_W] <= cap_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      load_line <= '0;
    end else if (load_en) begin
      load_line <= load_data;
    end
  end

  assign sel_data = load_line[sel_idx*BEAT_W +: BEAT_W];

endmodule

// File: rtl/line_burst_adapter.sv
// Cacheline to 4x64-bit burst adapter between arbiter and physical memory.
// Define LINE_BURST_ADAPTER_PERF_EN to add read/write/stall counters.
module line_burst_adapter
  import line_burst_pkg::*;
(
  input  logic clk,
  input  logic rst,
  line_burst_adapter_if.slave bus
`ifdef LINE_BURST_ADAPTER_PERF_EN
  ,
  output perf_t perf_reads,
  output perf_t perf_writes,
  output perf_t perf_stalls
`endif
);

  state_t     state;
  beat_t      beat;
  addr_t      addr_q;
  logic       in_read;
  logic       in_write;
  logic       active;
  logic       last;
  logic       accept_wr;
  logic       cap_en;
  line_t      cap_line;
  beat_data_t sel_data;

  assign in_read   = (state == READ);
  assign in_write  = (state == WRITE);
  assign active    = in_read | in_write;
  assign last      = (beat == LAST_BEAT);
  assign accept_wr = (state == IDLE) & bus.line_write;
  assign cap_en    = in_read & bus.burst_resp;

  // Write wins a simultaneous request so dirty writebacks go first.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      beat   <= '0;
      addr_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.line_write) begin
            addr_q <= line_align(bus.line_address);
            state  <= WRITE;
          end else if (bus.line_read) begin
            addr_q <= line_align(bus.line_address);
            state  <= READ;
          end
        end
        READ, WRITE: begin
          if (bus.burst_resp) begin
            beat <= beat + 1'b1;
            if (last) begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          beat  <= '0;
          state <= IDLE;
        end
        default: begin
          beat  <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  line_beat_buffer u_buf (
    .clk       (clk),
    .rst       (rst),
    .cap_en    (cap_en),
    .cap_idx   (beat),
    .cap_data  (bus.burst_rdata),
    .load_en   (accept_wr),
    .load_data (bus.line_wdata),
    .sel_idx   (beat),
    .cap_line  (cap_line),
    .sel_data  (sel_data)
  );

  assign bus.burst_read    = in_read;
  assign bus.burst_write   = in_write;
  assign bus.burst_address = active ? addr_q : '0;
  assign bus.burst_wdata   = in_write ? sel_data : '0;
  assign bus.line_resp     = (state == DONE);
  assign bus.line_rdata    = cap_line;

`ifdef LINE_BURST_ADAPTER_PERF_EN
  logic done_rd;
  logic done_wr;
  logic stall;

  assign done_rd = in_read & bus.burst_resp & last;
  assign done_wr = in_write & bus.burst_resp & last;
  assign stall   = active & ~bus.burst_resp;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_reads  <= '0;
      perf_writes <= '0;
      perf_stalls <= '0;
    end else begin
      if (done_rd) perf_reads  <= sat_inc(perf_reads);
      if (done_wr) perf_writes <= sat_inc(perf_writes);
      if (stall)   perf_stalls <= sat_inc(perf_stalls);
    end
  end
`endif

endmodule
